pipe_stage_buf: RTL
===================

# pipe_stage_buf

Parametrised pipeline buffer register for the RISC-V pipeline, the generalised successor to the fixed IF/ID, ID/EX, EX/MEM and MEM/WB buffer records. It carries an opaque packed payload of configurable width between two stages. It adds what the plain records lack:
- valid/ready handshake
- stage flush
- optional two-entry skid storage, so upstream `in_ready` comes from a register
- saturating back-pressure counter for performance analysis

## Interface
Parameters:
- `DATA_W`, default 41: payload width in bits. 41 is the IF/ID record: 9-bit PC + 32-bit instruction.
- `CNT_W`, default 16: width of the stall counter.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  upstream stage presents a payload.
- `in_ready`  out  1  buffer can accept a payload this cycle.
- `in_data`  in  DATA_W  upstream payload (packed stage record).
- `out_valid`  out  1  buffer holds a payload for the downstream stage.
- `out_ready`  in  1  downstream consumes the payload this cycle.
- `out_data`  out  DATA_W  payload to downstream.
- `flush`  in  1  synchronous kill of all held payloads (branch/jump redirect).
- `stall_cnt`  out  CNT_W  count of cycles with `out_valid=1` and `out_ready=0`.

## Operation
Handshakes:
- Input fire = `in_valid & in_ready`.
- Output fire = `out_valid & out_ready`.
- Payload order is strictly FIFO.
- Data is never duplicated or dropped, except by `flush`.

Skid mode (`PIPE_STAGE_SKID_EN` defined) holds a main entry and a skid entry. Occupancy state is EMPTY, ONE or TWO.
- EMPTY: input fire -> ONE, main <= `in_data`.
- ONE:
  - input fire and output fire -> ONE, main <= `in_data`.
  - input fire only -> TWO, skid <= `in_data`.
  - output fire only -> EMPTY.
  - neither -> ONE.
- TWO:
  - output fire -> ONE, main <= skid.
  - otherwise hold.
  - No input fire is possible, since `in_ready=0`.

Outputs in skid mode:
- `out_valid` = state != EMPTY.
- `out_data` = main.
- `in_ready` = state != TWO. It is decoded purely from state flops and has no combinational path from `out_ready`.

Flush:
- Highest priority. Next state = EMPTY regardless of handshakes.
- A payload accepted by input fire in the flush cycle is discarded.
- Payload flops are not cleared.
- `stall_cnt` is unaffected.

Stall counter:
- Increments by 1 in every cycle where `out_valid & ~out_ready`, including a flush cycle.
- Saturates at 2^CNT_W - 1; it never wraps.
- Cleared only by `reset`.

## Timing
- Reset values: `out_valid=0`, `out_data=0` (all payload flops 0), `in_ready=1`, `stall_cnt=0`, state EMPTY. These apply immediately on `reset` assertion, independent of `clk`.
- Reset mid-transfer discards all held payloads.
- Latency: a payload accepted at edge N is visible on `out_data` with `out_valid=1` after edge N, i.e. one cycle.
- Throughput: one payload per cycle when `out_ready` is held at 1.
- Skid mode: after one cycle of back-pressure from ONE, `in_ready` falls on the next edge. The payload accepted during that cycle is held in skid, not lost.
- `in_data` is sampled only on input fire. `out_data` remains stable while `out_valid=1` and `out_ready=0`.

## Configuration
- `PIPE_STAGE_SKID_EN` defined: two-entry skid behaviour as above, with registered `in_ready`.
- `PIPE_STAGE_SKID_EN` undefined:
  - Single entry only; states are EMPTY and ONE.
  - `in_ready = ~out_valid | out_ready`, which is combinational from `out_ready`.
  - Skid flops are not instantiated.
  - Flush, counter, reset and latency rules are unchanged.

## Test plan
- Streaming: `out_ready=1`, feed 0x001..0x010 on consecutive cycles -> `out_data` shows the same sequence one cycle later, `in_valid` never blocked, `stall_cnt=0`.
- Back-pressure (skid mode): with `out_ready=0`, send 0xA then 0xB -> state TWO, `in_ready=0`, `out_data=0xA`. Raise `out_ready` -> 0xA, then 0xB, then `out_valid=0`. `stall_cnt` equals the number of blocked cycles.
- Flush in TWO while `in_valid=1` with 0xC -> next cycle `out_valid=0`, `in_ready=1`; 0xA, 0xB and 0xC are never output.
- Saturation: `CNT_W=4`, `out_valid=1`, `out_ready=0` for 20 cycles -> `stall_cnt` stops at 15.
- Async reset: assert `reset` mid-cycle while in ONE -> `out_valid=0`, `in_ready=1`, `out_data=0` before the next edge.
- Macro off: `out_ready=0` with a payload held -> `in_ready=0` in the same cycle. Pulse `out_ready=1` while `in_valid=1` -> output fire and input fire occur in the same cycle.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: valid/ready pipeline register with flush and saturating stall counter.
// Define PIPE_STAGE_SKID_EN for a two-entry skid buffer with registered in_ready.
module pipe_stage_buf #(
  parameter int DATA_W = 41,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_cnt
);
`ifdef PIPE_STAGE_SKID_EN
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
`else
  typedef enum logic {EMPTY, ONE} state_t;
`endif
  state_t state, state_n;
  logic [DATA_W-1:0] main;
  logic in_fire, out_fire, load_main;
  assign out_valid = state != EMPTY;
  assign out_data  = main;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
`ifdef PIPE_STAGE_SKID_EN
  logic [DATA_W-1:0] skid;
  logic load_skid, main_from_skid;
  assign in_ready = state != TWO;
  always_comb begin
    state_n        = state;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state)
      EMPTY: if (in_fire) begin
        state_n   = ONE;
        load_main = 1'b1;
      end
      ONE: if (in_fire && out_fire) load_main = 1'b1;
      else if (in_fire) begin
        state_n   = TWO;
        load_skid = 1'b1;
      end
      else if (out_fire) state_n = EMPTY;
      default: if (out_fire) begin
        state_n        = ONE;
        main_from_skid = 1'b1;
      end
    endcase
    if (flush) state_n = EMPTY;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      main <= '0;
      skid <= '0;
    end else begin
      if (load_main) main <= in_data;
      else if (main_from_skid) main <= skid;
      if (load_skid) skid <= in_data;
    end
`else
  assign in_ready = ~out_valid | out_ready;
  always_comb begin
    load_main = in_fire;
    state_n   = flush ? EMPTY : in_fire ? ONE : out_fire ? EMPTY : state;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) main <= '0;
    else if (load_main) main <= in_data;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= EMPTY;
    else state <= state_n;
  always_ff @(posedge clk or posedge reset)
    if (reset) stall_cnt <= '0;
    else if (out_valid && !out_ready && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
endmodule
